// File: rtl/color_dominance_analyzer_pkg.sv
// -----------------------------------------------------------------------------
// color_pkg
// Shared definitions for the colour dominance analyser: result codes, pixel
// format selectors and the scan FSM state encoding.
// -----------------------------------------------------------------------------
package color_pkg;

    // Result codes reported on valor
    localparam logic [2:0] COLOR_RED   = 3'b100;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_BLUE  = 3'b001;
    localparam logic [2:0] COLOR_NONE  = 3'b000;

    // Pixel formats accepted on the frame-buffer data bus
    localparam int FMT_RGB332 = 0;
    localparam int FMT_RGB565 = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DECIDE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/color_dominance_analyzer_if.sv
// -----------------------------------------------------------------------------
// color_dominance_analyzer_if
// Bundles the control handshake (init/thr/busy/done), the result outputs
// (valor, cnt_r/g/b) and the frame-buffer read port (addr/rd_en/data).
//   slave  : analyser side
//   master : controller / frame-buffer side
// -----------------------------------------------------------------------------
interface color_dominance_analyzer_if #(
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 15
);
    logic              init;
    logic [2:0]        thr;
    logic [15:0]       data;
    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic              busy;
    logic              done;
    logic [2:0]        valor;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_g;
    logic [CNT_W-1:0]  cnt_b;

    modport master (
        output init, thr, data,
        input  addr, rd_en, busy, done, valor, cnt_r, cnt_g, cnt_b
    );

    modport slave (
        input  init, thr, data,
        output addr, rd_en, busy, done, valor, cnt_r, cnt_g, cnt_b
    );
endinterface

// File: rtl/color_dominance_analyzer_pixel_classifier.sv
// -----------------------------------------------------------------------------
// pixel_classifier
// Combinational pixel classifier. Normalises each channel to 3 bits for the
// configured pixel format and flags the pixel as red, green or blue when that
// channel alone reaches the threshold. At most one output is high.
// Ports:
//   data - frame-buffer word (upper byte ignored for RGB332)
//   thr  - channel threshold
//   is_r / is_g / is_b - one-hot classification (all low = unclassified)
// -----------------------------------------------------------------------------
module pixel_classifier
    import color_pkg::*;
#(
    parameter int PIX_FMT = FMT_RGB332
) (
    input  logic [15:0] data,
    input  logic [2:0]  thr,
    output logic        is_r,
    output logic        is_g,
    output logic        is_b
);
    logic [2:0] ch_r;
    logic [2:0] ch_g;
    logic [2:0] ch_b;
    logic       unused_hi;

    always_comb begin
        if (PIX_FMT == FMT_RGB565) begin
            ch_r = data[15:13];
            ch_g = data[10:8];
            ch_b = data[4:2];
        end else begin
            ch_r = data[7:5];
            ch_g = data[4:2];
            // 2-bit blue widened by repeating its MSB so full scale maps to 7
            ch_b = {data[1:0], data[1]};
        end
    end

    // Upper byte is only meaningful for RGB565
    assign unused_hi = ^data[15:8];

    assign is_r = (ch_r >= thr) && (ch_g < thr) && (ch_b < thr);
    assign is_g = (ch_g >= thr) && (ch_r < thr) && (ch_b < thr);
    assign is_b = (ch_b >= thr) && (ch_r < thr) && (ch_g < thr);

endmodule

// File: rtl/color_dominance_analyzer.sv
// -----------------------------------------------------------------------------
// color_dominance_analyzer
// Scans NUM_PIXELS frame-buffer words starting at BASE_ADDR on an init pulse,
// counts red/green/blue pixels and reports the dominant channel.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - slave modport: init/thr in, data in, addr/rd_en out,
//          busy/done/valor/cnt_r/cnt_g/cnt_b out
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for init; thr latched, counters cleared on start
// ST_READ   | one address per cycle, NUM_PIXELS cycles
// ST_DRAIN  | RD_LAT cycles for the last read data to arrive
// ST_DECIDE | pick winner, publish counts
// ST_DONE   | one-cycle done pulse, then back to idle
// -----------------------------------------------------------------------------
module color_dominance_analyzer
    import color_pkg::*;
#(
    parameter int          ADDR_W     = 15,
    parameter int          BASE_ADDR  = 0,
    parameter int          NUM_PIXELS = 19200,
    parameter int          PIX_FMT    = FMT_RGB332,
    parameter int          RD_LAT     = 1,
    parameter int unsigned MIN_COUNT  = 1,
    parameter int          CNT_W      = $clog2(NUM_PIXELS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    color_dominance_analyzer_if.slave  bus
);
    // Shared down-counter for the READ and DRAIN phases; needs room for
    // NUM_PIXELS-1 and RD_LAT-1 (<= 3).
    localparam int TMR_W = (CNT_W > 2) ? CNT_W : 2;

    state_t            state;
    state_t            state_nxt;
    logic [TMR_W-1:0]  tmr;
    logic              tmr_tc;

    logic              start;
    logic              ld_drain;
    logic              decide;
    logic              rd_en;
    logic              busy;
    logic              done;

    logic [ADDR_W-1:0] addr;
    logic [2:0]        thr_q;
    logic [RD_LAT-1:0] vld;
    logic              smp_vld;

    logic              is_r;
    logic              is_g;
    logic              is_b;

    logic [CNT_W-1:0]  acc_r;
    logic [CNT_W-1:0]  acc_g;
    logic [CNT_W-1:0]  acc_b;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_g;
    logic [CNT_W-1:0]  cnt_b;
    logic [2:0]        valor;
    logic [2:0]        valor_nxt;

    assign tmr_tc = (tmr == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        ld_drain  = 1'b0;
        decide    = 1'b0;
        rd_en     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (bus.init) begin
                    start     = 1'b1;
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                rd_en = 1'b1;
                if (tmr_tc) begin
                    ld_drain  = 1'b1;
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tmr_tc) begin
                    state_nxt = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                decide    = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else if (start) begin
            tmr <= TMR_W'(NUM_PIXELS - 1);
        end else if (ld_drain) begin
            tmr <= TMR_W'(RD_LAT - 1);
        end else if (!tmr_tc) begin
            tmr <= tmr - TMR_W'(1);
        end
    end

    // Address parks at BASE_ADDR outside READ so the first read cycle
    // presents it without a separate load; wraps modulo 2^ADDR_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= ADDR_W'(BASE_ADDR);
        end else if (state == ST_READ) begin
            addr <= addr + ADDR_W'(1);
        end else begin
            addr <= ADDR_W'(BASE_ADDR);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thr_q <= '0;
        end else if (start) begin
            thr_q <= bus.thr;
        end
    end

    // Oldest bit marks the cycle in which read data for an issued address
    // is present on bus.data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
        end else begin
            vld <= (vld << 1) | RD_LAT'(rd_en);
        end
    end

    assign smp_vld = vld[RD_LAT-1];

    pixel_classifier #(
        .PIX_FMT (PIX_FMT)
    ) u_classifier (
        .data (bus.data),
        .thr  (thr_q),
        .is_r (is_r),
        .is_g (is_g),
        .is_b (is_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
        end else if (start) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
        end else if (smp_vld) begin
            if (is_r) acc_r <= acc_r + CNT_W'(1);
            if (is_g) acc_g <= acc_g + CNT_W'(1);
            if (is_b) acc_b <= acc_b + CNT_W'(1);
        end
    end

    // Strict majority over both rivals plus the minimum-count floor;
    // ties and sparse results report none.
    always_comb begin
        valor_nxt = COLOR_NONE;
        if ((acc_r > acc_g) && (acc_r > acc_b) && (32'(acc_r) >= MIN_COUNT)) begin
            valor_nxt = COLOR_RED;
        end else if ((acc_g > acc_r) && (acc_g > acc_b) && (32'(acc_g) >= MIN_COUNT)) begin
            valor_nxt = COLOR_GREEN;
        end else if ((acc_b > acc_r) && (acc_b > acc_g) && (32'(acc_b) >= MIN_COUNT)) begin
            valor_nxt = COLOR_BLUE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valor <= COLOR_NONE;
            cnt_r <= '0;
            cnt_g <= '0;
            cnt_b <= '0;
        end else if (decide) begin
            valor <= valor_nxt;
            cnt_r <= acc_r;
            cnt_g <= acc_g;
            cnt_b <= acc_b;
        end
    end

    assign bus.addr  = addr;
    assign bus.rd_en = rd_en;
    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.valor = valor;
    assign bus.cnt_r = cnt_r;
    assign bus.cnt_g = cnt_g;
    assign bus.cnt_b = cnt_b;

endmodule

// File: tb/tb_color_dominance_analyzer.sv
module tb_color_dominance_analyzer;

    localparam int NP    = 16;
    localparam int AW    = 6;
    localparam int CW    = 5;
    localparam int NDUT  = 3;
    localparam int AMASK = (1 << AW) - 1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 3;
    endfunction
    function automatic int fmt_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic int min_of(input int i);
        return (i == 2) ? 4 : 1;
    endfunction
    function automatic int base_of(input int i);
        return (i == 0) ? 10 : (i == 1) ? 0 : 56;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        init_v [NDUT];
    logic [2:0]  thr_v  [NDUT];
    logic [15:0] mem    [NDUT][64];
    logic [15:0] pix    [NP];

    wire [AW-1:0] addr_v  [NDUT];
    wire          rd_en_v [NDUT];
    wire          busy_v  [NDUT];
    wire          done_v  [NDUT];
    wire [2:0]    valor_v [NDUT];
    wire [CW-1:0] cnt_r_v [NDUT];
    wire [CW-1:0] cnt_g_v [NDUT];
    wire [CW-1:0] cnt_b_v [NDUT];

    int checks = 0;
    int errors = 0;

    for (genvar i = 0; i < NDUT; i++) begin : g_dut
        color_dominance_analyzer_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

        color_dominance_analyzer #(
            .ADDR_W     (AW),
            .BASE_ADDR  (base_of(i)),
            .NUM_PIXELS (NP),
            .PIX_FMT    (fmt_of(i)),
            .RD_LAT     (lat_of(i)),
            .MIN_COUNT  (min_of(i)),
            .CNT_W      (CW)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Frame-buffer model: data for an address shows up RD_LAT cycles later
        logic [AW-1:0] pipe [4];
        always @(posedge clk) begin
            pipe[0] <= bus.addr;
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign bus.data = mem[i][pipe[lat_of(i)-1]];

        assign bus.init   = init_v[i];
        assign bus.thr    = thr_v[i];
        assign addr_v[i]  = bus.addr;
        assign rd_en_v[i] = bus.rd_en;
        assign busy_v[i]  = bus.busy;
        assign done_v[i]  = bus.done;
        assign valor_v[i] = bus.valor;
        assign cnt_r_v[i] = bus.cnt_r;
        assign cnt_g_v[i] = bus.cnt_g;
        assign cnt_b_v[i] = bus.cnt_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: classify each pixel from its channel values, then majority vote
    task automatic model(input int d, input int thr, output int cr, output int cg,
                         output int cb, output logic [2:0] v);
        cr = 0; cg = 0; cb = 0;
        for (int k = 0; k < NP; k++) begin
            int px, r, g, b;
            px = int'(pix[k]);
            if (fmt_of(d) == 0) begin
                r = (px >> 5) & 7;
                g = (px >> 2) & 7;
                b = ((px & 3) << 1) | ((px >> 1) & 1);
            end else begin
                r = (px >> 13) & 7;
                g = (px >> 8) & 7;
                b = (px >> 2) & 7;
            end
            if (r >= thr && g < thr && b < thr) cr++;
            if (g >= thr && r < thr && b < thr) cg++;
            if (b >= thr && r < thr && g < thr) cb++;
        end
        v = 3'b000;
        if (cr > cg && cr > cb && cr >= min_of(d)) v = 3'b100;
        if (cg > cr && cg > cb && cg >= min_of(d)) v = 3'b010;
        if (cb > cr && cb > cg && cb >= min_of(d)) v = 3'b001;
    endtask

    task automatic load(input int d);
        for (int k = 0; k < NP; k++) mem[d][(base_of(d) + k) & AMASK] = pix[k];
    endtask

    task automatic fill(input int from, input int n, input logic [15:0] val);
        for (int k = from; k < from + n; k++) pix[k] = val;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < NP; k++) pix[k] = 16'($urandom);
    endtask

    // Starts a scan from a negedge; optional stray init at cycle glitch (0 = none)
    task automatic do_scan(input int d, input logic [2:0] thr, input int glitch, input string tag);
        int cr, cg, cb;
        logic [2:0] ev;
        int n_done = 0;
        int done_cyc = -1;
        int addr_err = 0;
        logic busy_at_done = 1'b0;
        logic busy_after = 1'b1;
        logic [2:0] val_obs = '0;
        logic [CW-1:0] r_obs = '0, g_obs = '0, b_obs = '0;

        load(d);
        model(d, int'(thr), cr, cg, cb, ev);
        thr_v[d]  = thr;
        init_v[d] = 1'b1;
        @(posedge clk);
        #1 init_v[d] = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c <= NP) begin
                if (!(rd_en_v[d] === 1'b1 && busy_v[d] === 1'b1 &&
                      addr_v[d] === AW'((base_of(d) + c - 1) & AMASK))) addr_err++;
            end else if (rd_en_v[d] !== 1'b0) begin
                addr_err++;
            end
            if (done_v[d] === 1'b1) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc     = c;
                    busy_at_done = busy_v[d];
                    val_obs      = valor_v[d];
                    r_obs        = cnt_r_v[d];
                    g_obs        = cnt_g_v[d];
                    b_obs        = cnt_b_v[d];
                end
            end
            if (done_cyc > 0 && c == done_cyc + 1) busy_after = busy_v[d];
            if (c == glitch) begin
                init_v[d] = 1'b1;
                thr_v[d]  = ~thr;
            end else if (glitch > 0 && c == glitch + 1) begin
                init_v[d] = 1'b0;
                thr_v[d]  = thr;
            end
            if (done_cyc > 0 && c >= done_cyc + 3) break;
        end
        chk({tag, "_sweep"},    32'(addr_err), 32'd0);
        chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(NP + lat_of(d) + 2));
        chk({tag, "_n_done"},   32'(n_done), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy_at_done), 32'd1);
        chk({tag, "_busy_after"}, 32'(busy_after), 32'd0);
        chk({tag, "_valor"}, 32'(val_obs), 32'(ev));
        chk({tag, "_cnt_r"}, 32'(r_obs), 32'(cr));
        chk({tag, "_cnt_g"}, 32'(g_obs), 32'(cg));
        chk({tag, "_cnt_b"}, 32'(b_obs), 32'(cb));
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s%0d_busy", tag, d),  32'(busy_v[d]), 32'd0);
            chk($sformatf("%s%0d_done", tag, d),  32'(done_v[d]), 32'd0);
            chk($sformatf("%s%0d_rd_en", tag, d), 32'(rd_en_v[d]), 32'd0);
            chk($sformatf("%s%0d_valor", tag, d), 32'(valor_v[d]), 32'd0);
            chk($sformatf("%s%0d_addr", tag, d),  32'(addr_v[d]), 32'(base_of(d)));
            chk($sformatf("%s%0d_cnt", tag, d),
                32'({cnt_r_v[d], cnt_g_v[d], cnt_b_v[d]}), 32'd0);
        end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            init_v[d] = 1'b0;
            thr_v[d]  = 3'd0;
            for (int a = 0; a < 64; a++) mem[d][a] = 16'h0000;
        end
        for (int k = 0; k < NP; k++) pix[k] = 16'h0000;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst_init");
        rst = 1'b1;
        @(negedge clk);

        // DUT0: RGB332, RD_LAT=1, MIN_COUNT=1
        fill(0, 16, 16'h00E0);
        do_scan(0, 3'd4, 0, "all_red");

        // Reset in the middle of a scan
        fill(0, 16, 16'h001C);
        load(0);
        thr_v[0]  = 3'd4;
        init_v[0] = 1'b1;
        @(posedge clk);
        #1 init_v[0] = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_vals("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        fill(0, 6, 16'h001C);
        fill(6, 5, 16'h00E0);
        fill(11, 5, 16'h0003);
        do_scan(0, 3'd4, 0, "green_major");

        fill(0, 8, 16'h00E0);
        fill(8, 8, 16'h0003);
        do_scan(0, 3'd4, 0, "tie");

        fill_rand();
        do_scan(0, 3'd4, 5, "glitch");

        for (int n = 0; n < 3; n++) begin
            fill_rand();
            do_scan(0, 3'($urandom_range(7, 1)), 0, $sformatf("rand0_%0d", n));
        end

        // DUT1: RGB565, RD_LAT=2
        fill(0, 16, 16'h001F);
        do_scan(1, 3'd4, 0, "all_blue565");
        for (int n = 0; n < 2; n++) begin
            fill_rand();
            do_scan(1, 3'($urandom_range(7, 1)), 0, $sformatf("rand1_%0d", n));
        end

        // DUT2: RGB332, RD_LAT=3, MIN_COUNT=4, region wraps past address 63
        fill(0, 3, 16'h00E0);
        fill(3, 13, 16'h0000);
        do_scan(2, 3'd4, 0, "below_min");
        fill(0, 4, 16'h00E0);
        fill(4, 12, 16'h0000);
        do_scan(2, 3'd4, 0, "at_min");
        for (int n = 0; n < 2; n++) begin
            fill_rand();
            do_scan(2, 3'($urandom_range(7, 1)), 0, $sformatf("rand2_%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_dominance_analyzer.md
# color_dominance_analyzer

Parametrised frame analyser that scans a frame buffer region on request and reports the dominant colour channel (red, green or blue) of its pixels. It sits between the camera frame buffer read port and the SoC/LM32 register interface. It generalises the fixed 160×120 RGB332 analyser with these additions:
- configurable frame size and pixel format;
- frame-buffer read latency compensation;
- runtime threshold, minimum-count rejection and per-channel count outputs;
- a clean start/busy/done handshake.

## Interface
Parameters:
- ADDR_W, 15, frame-buffer address width
- BASE_ADDR, 0, first pixel address scanned
- NUM_PIXELS, 19200, pixels per scan (≥1)
- PIX_FMT, 0, 0 = RGB332 (data[7:0]), 1 = RGB565 (data[15:0])
- RD_LAT, 1, frame-buffer read latency in cycles (1..4)
- MIN_COUNT, 1, winner must have at least this many classified pixels
- CNT_W, $clog2(NUM_PIXELS+1), counter width (derived)

Ports:
- clk, in, 1, system clock
- rst, in, 1, reset, asynchronous, active-low
- init, in, 1, start-scan pulse; sampled only in IDLE
- thr, in, 3, channel threshold; latched on accepted init
- data, in, 16, frame-buffer read data; bits [15:8] ignored when PIX_FMT=0
- addr, out, ADDR_W, frame-buffer read address
- rd_en, out, 1, read strobe, high while an address is presented
- busy, out, 1, scan in progress
- done, out, 1, one-cycle pulse when result is updated
- valor, out, 3, result: 100 red, 010 green, 001 blue, 000 none/tie
- cnt_r / cnt_g / cnt_b, out, CNT_W each, per-channel pixel counts of the last scan

## Operation
- Channel normalisation to 3 bits:
  - RGB332: r = d[7:5], g = d[4:2], b = {d[1:0], d[1]}.
  - RGB565: r = d[15:13], g = d[10:8], b = d[4:2].
- Pixel classification. A pixel is red if r ≥ thr, g < thr and b < thr; green and blue are classified the same way. Any other pixel is unclassified and not counted.
- FSM states:
  - IDLE: on init go to READ. Clear the accumulators, latch thr, set addr = BASE_ADDR.
  - READ: rd_en = 1; addr increments by 1 each cycle. After NUM_PIXELS addresses go to DRAIN.
  - DRAIN: wait RD_LAT cycles for the last samples, then go to DECIDE.
  - DECIDE: compute valor, copy the accumulators to cnt_*, then go to DONE.
  - DONE: done = 1 for one cycle, then return to IDLE.
- Read pipeline: a valid shift register RD_LAT deep follows rd_en. A sample is accumulated on the edge where its valid bit is set.
- Decision: a channel wins only if its count is strictly greater than both other counts and ≥ MIN_COUNT; otherwise valor = 000.
- Widths: accumulators are CNT_W bits and cannot overflow. Address arithmetic is modulo 2^ADDR_W, so a region that passes the top of the address space wraps to 0.
- init while busy is ignored; there is no queuing.
- valor and cnt_* hold their values until the next DECIDE.

## Timing
- Reset (async assert, sync deassert by the system): addr = BASE_ADDR, rd_en = 0, busy = 0, done = 0, valor = 000, cnt_* = 0, FSM = IDLE.
- init sampled high at edge 0:
  - busy = 1 and rd_en = 1 from cycle 1.
  - addr = BASE_ADDR + k in cycle 1 + k, for k = 0..NUM_PIXELS−1.
- Data for the address presented in cycle c is valid in cycle c + RD_LAT.
- The last accumulation is at the end of cycle NUM_PIXELS + RD_LAT.
- DECIDE occurs in cycle NUM_PIXELS + RD_LAT + 1.
- In cycle NUM_PIXELS + RD_LAT + 2: done = 1, valor and cnt_* show the new values, busy = 1.
- busy = 0 from the next cycle. A new init is accepted in that cycle or later.
- Reset asserted mid-scan: all outputs return to their reset values immediately. Partial counts are discarded.
- init held high continuously: a new scan starts on the first IDLE cycle after each DONE.

## Structure
- Shared package color_pkg:
  - result code constants: COLOR_RED, COLOR_GREEN, COLOR_BLUE, COLOR_NONE;
  - PIX_FMT constants: FMT_RGB332, FMT_RGB565;
  - FSM state encoding.
- Sub-module pixel_classifier: purely combinational. Takes (data, thr, PIX_FMT) and produces one-hot {is_r, is_g, is_b}.
- The top level holds the FSM, address counter, valid pipeline, accumulators and decision logic.

## Test plan
All scenarios use NUM_PIXELS = 16 and a behavioural RAM model with the configured RD_LAT.
- RGB332, RD_LAT=1, all pixels 0xE0, thr=4 → cnt_r=16, cnt_g=0, cnt_b=0, valor=100; done exactly 19 cycles after the init edge; addr sweeps BASE..BASE+15.
- RGB332, pixels 6×0x1C, 5×0xE0, 5×0x03, thr=4 → cnt_g=6, cnt_r=5, cnt_b=5, valor=010.
- RGB332, 8×0xE0 and 8×0x03 → valor=000 (tie); cnt_r=8, cnt_b=8.
- RGB565, RD_LAT=2, all pixels 0x001F, thr=4 → cnt_b=16, valor=001; done 20 cycles after init.
- MIN_COUNT=4, 3×0xE0 and 13×0x00 → cnt_r=3, valor=000.
- Control sequence:
  - init pulsed at cycle 5 of a scan → ignored, with a single done;
  - rst asserted at cycle 8 → busy=0, done=0, valor=000, addr=BASE_ADDR asynchronously;
  - next init → a full scan from BASE_ADDR with correct counts.
